thresholding_cfg_sched: RTL and testbench
=========================================

// Module: thresholding_cfg_sched
// PURPOSE
// - Schedules the thresholding core's single configuration port (cfg_en/we/a/d, cfg_rack/q) between two requesters.
// - Requester H is the host: word-addressed read/write with a valid/ready handshake.
// - Requester L is a stream loader: it writes one complete threshold set from an AXI stream, generating addresses itself.
// - Sits between the AXI-lite adapter, the weight-reload DMA stream and the thresholding core.
// PARAMETERS
// - WT    32  threshold word width
// - N     1   thresholds per channel
// - C     1   channels
// - PE    1   parallelism; C = k*PE; CF = C/PE
// - SETS  1   independent threshold sets
// - Localparams: NB=$clog2(N), PB=$clog2(PE), FB=$clog2(CF), SB=$clog2(SETS), AW=SB+FB+PB+NB
// PORTS
// - clk          in   1    clock
// - rst          in   1    synchronous, active-high reset
// - h_vld        in   1    host request valid
// - h_rdy        out  1    host request accepted this cycle
// - h_we         in   1    1=write, 0=read
// - h_a          in   AW   host word address {set,cf,pe,n}
// - h_d          in   WT   host write data
// - h_rack       out  1    host read data valid
// - h_q          out  WT   host read data
// - ld_start     in   1    start loading set ld_set
// - ld_set       in   S    set to load; S=max(SB,1)
// - ld_busy      out  1    load in progress
// - ld_done      out  1    1-cycle pulse: last word of set written
// - ld_err       out  1    sticky: TLAST misplaced; cleared by ld_start
// - s_tvalid     in   1    threshold stream valid
// - s_tready     out  1    threshold stream ready
// - s_tdata      in   WT   threshold word
// - s_tlast      in   1    last word of set
// - cfg_en       out  1    to core
// - cfg_we       out  1    to core
// - cfg_a        out  AW   to core
// - cfg_d        out  WT   to core
// - cfg_rack     in   1    from core
// - cfg_q        in   WT   from core
// BEHAVIOUR
// - Reset values: cfg_en=0, cfg_we=0, cfg_a=0, cfg_d=0; ld_busy=0, ld_done=0, ld_err=0; rr token=H; state IDLE; address counter 0.
// - State machine:
//   - IDLE: ld_start -> LOAD. Counter is set to {ld_set,0,0,0} and ld_err cleared.
//   - LOAD: after the beat with counter == {ld_set,CF-1,PE-1,N-1} -> IDLE, with ld_done pulsed in the following cycle.
//   - ld_start while in LOAD is ignored.
// - Requests: req_L = (state==LOAD) && s_tvalid; req_H = h_vld.
// - Grant: one request per cycle. A sole requester always wins. If both request, the rr token decides, and the token flips to the loser after every contested grant.
// - Handshakes: h_rdy = grant_H; s_tready = grant_L. Both are combinational from the inputs and the registered state. s_tready=0 in IDLE.
// - Latency: a grant in cycle t drives cfg_* registered in t+1, for exactly one cycle. cfg_en=0 in cycles with no grant.
// - L beats are writes: cfg_we=1, cfg_a=counter, cfg_d=s_tdata.
// - Address counter: mixed-radix n -> pe -> cf. Each field wraps at N-1 / PE-1 / CF-1 and carries into the next field up. The set field is held. Unused codes (e.g. n>=N for non-power-of-2 N) are never emitted.
// - TLAST check: ld_err is set if s_tlast=1 on a non-final beat, or s_tlast=0 on the final beat. The load still runs to the full count.
// - Reads: h_rack=cfg_rack and h_q=cfg_q are passthroughs. Only H issues reads, so ordering is inherent.
// - Reset mid-load: abandons the load, returns to IDLE, and drops all pending outputs. The core keeps any words already written.
// CONFIGURATION
// - THRESHOLDING_CFG_LOCK_EN defined: while in LOAD, h_rdy is forced to 0. H is stalled until the load ends, so a set is updated atomically with respect to the host.
// - Undefined: round-robin interleaving as above.
// STRUCTURE
// - Package thresholding_cfg_pkg holds:
//   - typedef cfg_addr_t, a packed struct {set,cf,pe,n} of widths SB/FB/PB/NB;
//   - typedef enum sched_state_e {IDLE,LOAD};
//   - function addr_next(), the mixed-radix increment with a final flag.
// - Sub-module thresholding_cfg_addr_cnt: loadable mixed-radix counter with load/inc inputs and a last output.
// TESTING
// - Host only, no contention: 3 writes then 1 read of addr 5.
//   -> h_rdy=1 every cycle; cfg_en one cycle after each grant; h_q equals the written value on h_rack.
// - N=3, PE=2, CF=2, SETS=2; ld_start with ld_set=1; 12 beats, TLAST on beat 12.
//   -> cfg_a = {1,0,0,0..2}, {1,0,1,0..2}, {1,1,0,0..2}, {1,1,1,0..2}; ld_done one cycle after the last cfg_en; ld_err=0.
// - Both requesters valid continuously during a load.
//   -> grants alternate H,L,H,L; the load takes 24 cycles; no beat is lost or duplicated.
// - TLAST on beat 7 of 12.
//   -> ld_err=1 (sticky); all 12 words are still written; ld_done pulses; the next ld_start clears ld_err.
// - rst asserted at beat 5.
//   -> next cycle cfg_en=0, ld_busy=0, s_tready=0. A new ld_start restarts at n=0 of the requested set.
// - With THRESHOLDING_CFG_LOCK_EN: h_vld held during a load.
//   -> h_rdy=0 until the cycle after the last beat; the host write is issued afterwards.

Source files
------------

// File: rtl/thresholding_cfg_pkg.sv
// Shared types for the thresholding configuration scheduler: address fields, FSM states
// and the mixed-radix address step used by the loader's counter.
package thresholding_cfg_pkg;

   localparam int FW = 8;

   // Fields are held at a fixed width; the packed core address is built from them by shifting.
   typedef struct packed {
      logic [FW-1:0] set;
      logic [FW-1:0] cf;
      logic [FW-1:0] pe;
      logic [FW-1:0] n;
   } cfg_addr_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } sched_state_e;

   typedef struct packed {
      cfg_addr_t nxt;
      logic      last;
   } addr_step_t;

   function automatic int max1(input int x);
      return (x > 1) ? x : 1;
   endfunction

   function automatic addr_step_t addr_next(input cfg_addr_t a,
                                            input logic [FW-1:0] n_max,
                                            input logic [FW-1:0] pe_max,
                                            input logic [FW-1:0] cf_max);
      addr_step_t r;
      r.nxt  = a;
      r.last = 1'b0;
      if (a.n != n_max) begin
         r.nxt.n = a.n + 8'd1;
      end else begin
         r.nxt.n = '0;
         if (a.pe != pe_max) begin
            r.nxt.pe = a.pe + 8'd1;
         end else begin
            r.nxt.pe = '0;
            if (a.cf != cf_max) begin
               r.nxt.cf = a.cf + 8'd1;
            end else begin
               r.nxt.cf = '0;
               r.last   = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/thresholding_cfg_sched_if.sv
// Host word-access port of the thresholding configuration scheduler.
interface thresholding_cfg_sched_if #(
   parameter int WT = 32,
   parameter int AW = 1
);
   logic          h_vld;
   logic          h_rdy;
   logic          h_we;
   logic [AW-1:0] h_a;
   logic [WT-1:0] h_d;
   logic          h_rack;
   logic [WT-1:0] h_q;

   modport master (output h_vld, h_we, h_a, h_d, input h_rdy, h_rack, h_q);
   modport slave  (input h_vld, h_we, h_a, h_d, output h_rdy, h_rack, h_q);
endinterface

// File: rtl/thresholding_cfg_addr_cnt.sv
// Loadable mixed-radix address counter (n -> pe -> cf) for the threshold loader; the set
// field is held at its loaded value.
module thresholding_cfg_addr_cnt
   import thresholding_cfg_pkg::*;
#(
   parameter int N    = 1,
   parameter int PE   = 1,
   parameter int CF   = 1,
   parameter int SETS = 1,
   parameter int AW   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [FW-1:0] load_set,
   input  logic          inc,
   output logic [AW-1:0] addr,
   output logic          last
);
   localparam int NB = $clog2(N);
   localparam int PB = $clog2(PE);
   localparam int FB = $clog2(CF);
   localparam int SB = $clog2(SETS);
   localparam logic [FW-1:0] N_MAX    = FW'(N - 1);
   localparam logic [FW-1:0] PE_MAX   = FW'(PE - 1);
   localparam logic [FW-1:0] CF_MAX   = FW'(CF - 1);
   localparam logic [FW-1:0] SET_MASK = FW'((1 << SB) - 1);

   cfg_addr_t  cnt_q;
   addr_step_t step;

   assign step = addr_next(cnt_q, N_MAX, PE_MAX, CF_MAX);
   assign last = step.last;
   assign addr = AW'((32'(cnt_q.set) << (FB + PB + NB)) | (32'(cnt_q.cf) << (PB + NB)) |
                     (32'(cnt_q.pe) << NB) | 32'(cnt_q.n));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q     <= '0;
         cnt_q.set <= load_set & SET_MASK;
      end else if (inc) begin
         cnt_q <= step.nxt;
      end
   end

endmodule

// File: rtl/thresholding_cfg_sched.sv
// Arbitrates the thresholding core's config port between the host and the stream loader.
// Build option THRESHOLDING_CFG_LOCK_EN: stall the host for the whole duration of a load.
module thresholding_cfg_sched
   import thresholding_cfg_pkg::*;
#(
   parameter int WT   = 32,
   parameter int N    = 1,
   parameter int C    = 1,
   parameter int PE   = 1,
   parameter int SETS = 1,
   localparam int CF  = C / PE,
   localparam int NB  = $clog2(N),
   localparam int PB  = $clog2(PE),
   localparam int FB  = $clog2(CF),
   localparam int SB  = $clog2(SETS),
   localparam int AW  = max1(SB + FB + PB + NB),
   localparam int S   = max1(SB)
) (
   input  logic                     clk,
   input  logic                     rst,
   thresholding_cfg_sched_if.slave  h,
   input  logic                     ld_start,
   input  logic [S-1:0]             ld_set,
   output logic                     ld_busy,
   output logic                     ld_done,
   output logic                     ld_err,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic [WT-1:0]            s_tdata,
   input  logic                     s_tlast,
   output logic                     cfg_en,
   output logic                     cfg_we,
   output logic [AW-1:0]            cfg_a,
   output logic [WT-1:0]            cfg_d,
   input  logic                     cfg_rack,
   input  logic [WT-1:0]            cfg_q
);
   // state | meaning
   // IDLE  | no load; only host requests are served
   // LOAD  | streaming a threshold set; host and loader share the port round-robin

   sched_state_e  state_q, state_d;
   logic          rr_q;            // 0: host holds the token, 1: loader holds it
   logic          req_h, req_l, gnt_h, gnt_l;
   logic          cnt_load, cnt_last;
   logic [AW-1:0] cnt_a;
   logic          done_pend_q;

`ifdef THRESHOLDING_CFG_LOCK_EN
   assign req_h = h.h_vld && (state_q != LOAD);
`else
   assign req_h = h.h_vld;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      req_l    = (state_q == LOAD) && s_tvalid;
      gnt_h    = req_h && (!req_l || !rr_q);
      gnt_l    = req_l && (!req_h || rr_q);
      case (state_q)
         IDLE: if (ld_start) begin
            state_d  = LOAD;
            cnt_load = 1'b1;
         end
         LOAD: if (gnt_l && cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign h.h_rdy  = gnt_h;
   assign s_tready = gnt_l;
   assign ld_busy  = (state_q == LOAD);
   assign h.h_rack = cfg_rack;
   assign h.h_q    = cfg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         cfg_en      <= 1'b0;
         cfg_we      <= 1'b0;
         cfg_a       <= '0;
         cfg_d       <= '0;
         done_pend_q <= 1'b0;
         ld_done     <= 1'b0;
         ld_err      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req_h && req_l) rr_q <= ~rr_q;
         cfg_en <= gnt_h | gnt_l;
         cfg_we <= gnt_l | (gnt_h & h.h_we);
         if (gnt_l) begin
            cfg_a <= cnt_a;
            cfg_d <= s_tdata;
         end else if (gnt_h) begin
            cfg_a <= h.h_a;
            cfg_d <= h.h_d;
         end
         done_pend_q <= gnt_l && cnt_last;
         ld_done     <= done_pend_q;
         // TLAST is only advisory: a mismatch flags the set but the full count is still written.
         if (cnt_load) ld_err <= 1'b0;
         else if (gnt_l && (s_tlast != cnt_last)) ld_err <= 1'b1;
      end
   end

   thresholding_cfg_addr_cnt #(
      .N(N), .PE(PE), .CF(CF), .SETS(SETS), .AW(AW)
   ) u_addr_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_set (FW'(ld_set)),
      .inc      (gnt_l),
      .addr     (cnt_a),
      .last     (cnt_last)
   );

endmodule

// File: tb/tb_thresholding_cfg_sched.sv
// Directed bench for thresholding_cfg_sched with N=3, PE=2, C=4, SETS=2 and a small core model.
module tb_thresholding_cfg_sched;
   localparam int WT = 32, N = 3, C = 4, PE = 2, SETS = 2, AW = 5, S = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ld_start = 1'b0;
   logic [S-1:0]  ld_set = '0;
   logic          ld_busy, ld_done, ld_err;
   logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [WT-1:0] s_tdata = '0;
   logic          cfg_en, cfg_we;
   logic [AW-1:0] cfg_a;
   logic [WT-1:0] cfg_d;
   logic          cfg_rack;
   logic [WT-1:0] cfg_q;
   logic [WT-1:0] mem [0:31];
   logic [AW-1:0] exp_a;
   int            total = 0, bad = 0;

   always #5 clk = ~clk;

   thresholding_cfg_sched_if #(.WT(WT), .AW(AW)) hif ();

   thresholding_cfg_sched #(.WT(WT), .N(N), .C(C), .PE(PE), .SETS(SETS)) dut (
      .clk(clk), .rst(rst), .h(hif),
      .ld_start(ld_start), .ld_set(ld_set), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
      .cfg_rack(cfg_rack), .cfg_q(cfg_q)
   );

   // Core model: write on cfg_en&we, read data returned one cycle later.
   always @(posedge clk) begin
      cfg_rack <= 1'b0;
      if (cfg_en) begin
         if (cfg_we) mem[cfg_a] <= cfg_d;
         else begin
            cfg_rack <= 1'b1;
            cfg_q    <= mem[cfg_a];
         end
      end
   end

   function automatic logic [AW-1:0] ea(input int set, input int b);
      return AW'(set * 16 + (b / 6) * 8 + ((b / 3) % 2) * 4 + (b % 3));
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int set);
      ld_set   = S'(set);
      ld_start = 1'b1;
      tick;
      ld_start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; s_tvalid = 1'b1; hif.h_vld = 1'b0;
      tick; tick;
      total++; if (cfg_en !== 1'b0) begin bad++; $display("FAIL rst_cfg_en got=%b exp=0", cfg_en); end
      total++; if (cfg_we !== 1'b0) begin bad++; $display("FAIL rst_cfg_we got=%b exp=0", cfg_we); end
      total++; if (cfg_a !== '0) begin bad++; $display("FAIL rst_cfg_a got=%0d exp=0", cfg_a); end
      total++; if (cfg_d !== '0) begin bad++; $display("FAIL rst_cfg_d got=%h exp=0", cfg_d); end
      total++; if (ld_busy !== 1'b0) begin bad++; $display("FAIL rst_ld_busy got=%b exp=0", ld_busy); end
      total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL rst_ld_done got=%b exp=0", ld_done); end
      total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL rst_ld_err got=%b exp=0", ld_err); end
      rst = 1'b0;
      #1;
      total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL idle_tready got=%b exp=0", s_tready); end
      s_tvalid = 1'b0;
      tick;
   endtask

   task automatic test_host;
      logic [AW-1:0] addrs [3];
      logic [WT-1:0] data  [3];
      addrs = '{5'd5, 5'd6, 5'd9};
      data  = '{32'h1111_0005, 32'h2222_0006, 32'h3333_0009};
      for (int i = 0; i < 3; i++) begin
         hif.h_vld = 1'b1; hif.h_we = 1'b1; hif.h_a = addrs[i]; hif.h_d = data[i];
         #1;
         total++; if (hif.h_rdy !== 1'b1) begin bad++; $display("FAIL host_rdy i=%0d got=%b exp=1", i, hif.h_rdy); end
         tick;
         total++; if (cfg_en !== 1'b1 || cfg_we !== 1'b1 || cfg_a !== addrs[i] || cfg_d !== data[i]) begin
            bad++; $display("FAIL host_wr i=%0d got en=%b we=%b a=%0d d=%h exp en=1 we=1 a=%0d d=%h",
                            i, cfg_en, cfg_we, cfg_a, cfg_d, addrs[i], data[i]);
         end
      end
      hif.h_we = 1'b0; hif.h_a = 5'd5;
      #1;
      total++; if (hif.h_rdy !== 1'b1) begin bad++; $display("FAIL host_rd_rdy got=%b exp=1", hif.h_rdy); end
      tick;
      hif.h_vld = 1'b0;
      total++; if (cfg_en !== 1'b1 || cfg_we !== 1'b0 || cfg_a !== 5'd5) begin
         bad++; $display("FAIL host_rd_issue got en=%b we=%b a=%0d exp en=1 we=0 a=5", cfg_en, cfg_we, cfg_a);
      end
      tick;
      total++; if (cfg_en !== 1'b0) begin bad++; $display("FAIL host_idle_en got=%b exp=0", cfg_en); end
      total++; if (hif.h_rack !== 1'b1 || hif.h_q !== 32'h1111_0005) begin
         bad++; $display("FAIL host_rd_data got rack=%b q=%h exp rack=1 q=11110005", hif.h_rack, hif.h_q);
      end
   endtask

   task automatic test_load;
      start_load(1);
      total++; if (ld_busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b exp=1", ld_busy); end
      for (int b = 0; b < 12; b++) begin
         s_tvalid = 1'b1; s_tdata = 32'h100 + b; s_tlast = (b == 11);
         #1;
         total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL load_tready b=%0d got=%b exp=1", b, s_tready); end
         tick;
         exp_a = ea(1, b);
         total++; if (cfg_en !== 1'b1 || cfg_we !== 1'b1 || cfg_a !== exp_a || cfg_d !== 32'h100 + b) begin
            bad++; $display("FAIL load_beat b=%0d got en=%b we=%b a=%0d d=%h exp a=%0d d=%h",
                            b, cfg_en, cfg_we, cfg_a, cfg_d, exp_a, 32'h100 + b);
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      total++; if (ld_busy !== 1'b0 || ld_done !== 1'b0) begin
         bad++; $display("FAIL load_end got busy=%b done=%b exp busy=0 done=0", ld_busy, ld_done);
      end
      tick;
      total++; if (ld_done !== 1'b1 || cfg_en !== 1'b0) begin
         bad++; $display("FAIL load_done got done=%b en=%b exp done=1 en=0", ld_done, cfg_en);
      end
      tick;
      total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", ld_done); end
      total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL load_err got=%b exp=0", ld_err); end
   endtask

   task automatic test_back_to_back;
      int j, b;
      start_load(1);
      for (int k = 0; k < 24; k++) begin
         j = (k + 1) / 2; b = k / 2;
         hif.h_vld = 1'b1; hif.h_we = 1'b1; hif.h_a = AW'(j); hif.h_d = 32'hA00 + j;
         s_tvalid = 1'b1; s_tdata = 32'h200 + b; s_tlast = (b == 11);
         #1;
         total++; if (hif.h_rdy !== (k % 2 == 0) || s_tready !== (k % 2 == 1)) begin
            bad++; $display("FAIL rr_grant k=%0d got h_rdy=%b s_tready=%b exp h_rdy=%0d", k, hif.h_rdy, s_tready, (k % 2 == 0));
         end
         tick;
         exp_a = (k % 2 == 0) ? AW'(j) : ea(1, b);
         total++; if (cfg_en !== 1'b1 || cfg_a !== exp_a) begin
            bad++; $display("FAIL rr_addr k=%0d got en=%b a=%0d exp en=1 a=%0d", k, cfg_en, cfg_a, exp_a);
         end
      end
      hif.h_vld = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      total++; if (ld_busy !== 1'b0) begin bad++; $display("FAIL rr_busy got=%b exp=0", ld_busy); end
      tick;
      total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL rr_done got=%b exp=1", ld_done); end
      for (int i = 0; i < 12; i++) begin
         total++; if (mem[ea(1, i)] !== 32'h200 + i) begin
            bad++; $display("FAIL rr_ld_word i=%0d got=%h exp=%h", i, mem[ea(1, i)], 32'h200 + i);
         end
         total++; if (mem[i] !== 32'hA00 + i) begin
            bad++; $display("FAIL rr_host_word i=%0d got=%h exp=%h", i, mem[i], 32'hA00 + i);
         end
      end
      tick;
   endtask

   task automatic test_lock;
      start_load(1);
      hif.h_vld = 1'b1; hif.h_we = 1'b1; hif.h_a = 5'd3; hif.h_d = 32'hBEEF;
      for (int b = 0; b < 12; b++) begin
         s_tvalid = 1'b1; s_tdata = 32'h500 + b; s_tlast = (b == 11);
         #1;
         total++; if (hif.h_rdy !== 1'b0 || s_tready !== 1'b1) begin
            bad++; $display("FAIL lock_grant b=%0d got h_rdy=%b s_tready=%b exp 0 1", b, hif.h_rdy, s_tready);
         end
         tick;
         exp_a = ea(1, b);
         total++; if (cfg_a !== exp_a) begin bad++; $display("FAIL lock_addr b=%0d got=%0d exp=%0d", b, cfg_a, exp_a); end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      total++; if (hif.h_rdy !== 1'b1) begin bad++; $display("FAIL lock_release got=%b exp=1", hif.h_rdy); end
      tick;
      hif.h_vld = 1'b0;
      total++; if (cfg_en !== 1'b1 || cfg_a !== 5'd3 || cfg_d !== 32'hBEEF) begin
         bad++; $display("FAIL lock_host_wr got en=%b a=%0d d=%h exp en=1 a=3 d=0000beef", cfg_en, cfg_a, cfg_d);
      end
      tick; tick;
   endtask

   task automatic test_tlast_err;
      start_load(0);
      for (int b = 0; b < 12; b++) begin
         s_tvalid = 1'b1; s_tdata = 32'h300 + b; s_tlast = (b == 6);
         tick;
         exp_a = ea(0, b);
         total++; if (cfg_en !== 1'b1 || cfg_a !== exp_a) begin
            bad++; $display("FAIL err_beat b=%0d got en=%b a=%0d exp en=1 a=%0d", b, cfg_en, cfg_a, exp_a);
         end
         total++; if (ld_err !== (b >= 6)) begin
            bad++; $display("FAIL err_flag b=%0d got=%b exp=%0d", b, ld_err, (b >= 6));
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      tick;
      total++; if (ld_done !== 1'b1 || ld_err !== 1'b1) begin
         bad++; $display("FAIL err_done got done=%b err=%b exp done=1 err=1", ld_done, ld_err);
      end
      start_load(1);
      total++; if (ld_err !== 1'b0 || ld_busy !== 1'b1) begin
         bad++; $display("FAIL err_clear got err=%b busy=%b exp err=0 busy=1", ld_err, ld_busy);
      end
   endtask

   task automatic test_reset_mid_load;
      for (int b = 0; b < 4; b++) begin
         s_tvalid = 1'b1; s_tdata = 32'h600 + b; s_tlast = 1'b0;
         tick;
         exp_a = ea(1, b);
         total++; if (cfg_a !== exp_a) begin bad++; $display("FAIL mid_addr b=%0d got=%0d exp=%0d", b, cfg_a, exp_a); end
      end
      s_tdata = 32'h604; rst = 1'b1;
      tick;
      total++; if (cfg_en !== 1'b0 || ld_busy !== 1'b0 || s_tready !== 1'b0) begin
         bad++; $display("FAIL mid_rst got en=%b busy=%b tready=%b exp 0 0 0", cfg_en, ld_busy, s_tready);
      end
      rst = 1'b0; s_tvalid = 1'b0;
      tick;
      start_load(1);
      s_tvalid = 1'b1; s_tdata = 32'h700;
      #1;
      total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL mid_restart_tready got=%b exp=1", s_tready); end
      tick;
      s_tvalid = 1'b0;
      total++; if (cfg_en !== 1'b1 || cfg_a !== 5'd16 || cfg_d !== 32'h700) begin
         bad++; $display("FAIL mid_restart got en=%b a=%0d d=%h exp en=1 a=16 d=00000700", cfg_en, cfg_a, cfg_d);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      hif.h_vld = 1'b0; hif.h_we = 1'b0; hif.h_a = '0; hif.h_d = '0;
      test_reset;
      test_host;
      test_load;
`ifdef THRESHOLDING_CFG_LOCK_EN
      test_lock;
`else
      test_back_to_back;
`endif
      test_tlast_err;
      test_reset_mid_load;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
